// File: rtl/mda_crtc_pkg.sv
// Shared constants for the MDA CRTC: register indices, port offsets,
// mode-register bit positions and the cursor blink mode encoding.
package mda_pkg;

    localparam logic [4:0] R_CUR_START = 5'd10;
    localparam logic [4:0] R_CUR_END   = 5'd11;
    localparam logic [4:0] R_START_HI  = 5'd12;
    localparam logic [4:0] R_START_LO  = 5'd13;
    localparam logic [4:0] R_CUR_HI    = 5'd14;
    localparam logic [4:0] R_CUR_LO    = 5'd15;

    localparam logic [3:0] OFF_MODE   = 4'd8;
    localparam logic [3:0] OFF_STATUS = 4'd10;

    localparam int MODE_HIRES = 0;
    localparam int MODE_VIDEO = 3;
    localparam int MODE_BLINK = 5;

    typedef enum logic [1:0] {
        CUR_STEADY = 2'b00,
        CUR_OFF    = 2'b01,
        CUR_FAST   = 2'b10,
        CUR_SLOW   = 2'b11
    } cursor_mode_e;

endpackage

// File: rtl/mda_crtc_if.sv
// CPU I/O bus between a bus master and the MDA CRTC register block.
// Strobes are single-cycle; oIoAck pulses one cycle after a decoded access.
interface mda_crtc_if;
    logic [15:0] iIoAddr;
    logic [7:0]  iIoData;
    logic        iIoWr;
    logic        iIoRd;
    logic [7:0]  oIoData;
    logic        oIoAck;

    modport master (output iIoAddr, iIoData, iIoWr, iIoRd,
                    input  oIoData, oIoAck);
    modport slave  (input  iIoAddr, iIoData, iIoWr, iIoRd,
                    output oIoData, oIoAck);
endinterface

// File: rtl/mda_crtc_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a rising-edge pulse
// taken from a third flop that resets low (a level high out of reset is an edge).
module mda_sync_edge (
    input  logic iClk,
    input  logic iRst,
    input  logic iAsync,
    output logic oSync,
    output logic oRise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= iAsync;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign oSync = r_sync;
    assign oRise = r_sync & ~r_prev;

endmodule

// File: rtl/mda_crtc.sv
// MDA CRTC CPU-side register file: 6845-style index/data pair, mode and status.
// Optional macro MDA_CRTC_SHADOW_EN: start address latched at vblank for tear-free scrolling.
module mda_crtc
    import mda_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'h03B0,
    parameter int          BLINK_BITS = 5
) (
    input  logic        iClk,
    input  logic        iRst,
    mda_crtc_if.slave   io,
    input  logic        iVBlank,
    input  logic        iBlank,
    output logic [13:0] oStartAddr,
    output logic [13:0] oCursorAddr,
    output logic [4:0]  oCursorStart,
    output logic [4:0]  oCursorEnd,
    output logic        oCursorOn,
    output logic        oAttrBlink,
    output logic        oVideoEn,
    output logic        oHiRes,
    output logic        oBlinkEn
);

    logic [15:0] w_off;
    logic [3:0]  w_sel;
    logic        w_hit, w_wr, w_rd, w_idx_sel, w_data_sel;
    logic        w_vb_s, w_vb_rise, w_bl_s, w_bl_rise;
    logic [7:0]  w_rdata;
    logic        w_unused;
    cursor_mode_e w_cur_mode;

    logic [4:0]  r_index;
    logic [6:0]  r_r10;
    logic [4:0]  r_r11;
    logic [5:0]  r_r12;
    logic [7:0]  r_r13;
    logic [5:0]  r_r14;
    logic [7:0]  r_r15;
    logic [5:0]  r_mode;
    logic [BLINK_BITS-1:0] r_cnt;
    logic        r_ack;
    logic [7:0]  r_rdata;
`ifdef MDA_CRTC_SHADOW_EN
    logic [5:0]  r_s12;
    logic [7:0]  r_s13;
`endif

    mda_sync_edge u_vb_sync (.iClk(iClk), .iRst(iRst), .iAsync(iVBlank),
                             .oSync(w_vb_s), .oRise(w_vb_rise));
    mda_sync_edge u_bl_sync (.iClk(iClk), .iRst(iRst), .iAsync(iBlank),
                             .oSync(w_bl_s), .oRise(w_bl_rise));

    // Addresses below BASE wrap to large offsets and miss the decode.
    assign w_off      = io.iIoAddr - BASE;
    assign w_sel      = w_off[3:0];
    assign w_hit      = (w_off[15:4] == 12'd0);
    assign w_wr       = io.iIoWr & w_hit;
    assign w_rd       = io.iIoRd & ~io.iIoWr & w_hit;
    assign w_idx_sel  = ~w_sel[3] & ~w_sel[0];
    assign w_data_sel = ~w_sel[3] &  w_sel[0];

    always_comb begin
        w_rdata = 8'hFF;
        if (w_idx_sel) begin
            w_rdata = {3'b000, r_index};
        end else if (w_data_sel) begin
            w_rdata = 8'h00;
            if (r_index == R_CUR_HI)
                w_rdata = {2'b00, r_r14};
            else if (r_index == R_CUR_LO)
                w_rdata = r_r15;
        end else if (w_sel == OFF_STATUS) begin
            w_rdata = {4'hF, w_vb_s, 2'b00, w_bl_s};
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_index <= '0;
            r_r10   <= '0;
            r_r11   <= '0;
            r_r12   <= '0;
            r_r13   <= '0;
            r_r14   <= '0;
            r_r15   <= '0;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
`ifdef MDA_CRTC_SHADOW_EN
            r_s12   <= '0;
            r_s13   <= '0;
`endif
        end else begin
            r_ack <= w_wr | w_rd;
            if (w_rd)
                r_rdata <= w_rdata;
            if (w_wr) begin
                if (w_idx_sel) begin
                    r_index <= io.iIoData[4:0];
                end else if (w_data_sel) begin
                    case (r_index)
                        R_CUR_START: r_r10 <= io.iIoData[6:0];
                        R_CUR_END:   r_r11 <= io.iIoData[4:0];
`ifdef MDA_CRTC_SHADOW_EN
                        R_START_HI:  r_s12 <= io.iIoData[5:0];
                        R_START_LO:  r_s13 <= io.iIoData;
`else
                        R_START_HI:  r_r12 <= io.iIoData[5:0];
                        R_START_LO:  r_r13 <= io.iIoData;
`endif
                        R_CUR_HI:    r_r14 <= io.iIoData[5:0];
                        R_CUR_LO:    r_r15 <= io.iIoData;
                        default:     ;
                    endcase
                end else if (w_sel == OFF_MODE) begin
                    r_mode <= io.iIoData[5:0];
                end
            end
            if (w_vb_rise)
                r_cnt <= r_cnt + 1'b1;
`ifdef MDA_CRTC_SHADOW_EN
            if (w_vb_rise) begin
                r_r12 <= r_s12;
                r_r13 <= r_s13;
            end
`endif
        end
    end

    assign w_cur_mode = cursor_mode_e'(r_r10[6:5]);

    always_comb begin
        oCursorOn = 1'b1;
        case (w_cur_mode)
            CUR_STEADY: oCursorOn = 1'b1;
            CUR_OFF:    oCursorOn = 1'b0;
            CUR_FAST:   oCursorOn = r_cnt[3];
            CUR_SLOW:   oCursorOn = r_cnt[4];
            default:    oCursorOn = 1'b1;
        endcase
    end

    assign oStartAddr   = {r_r12, r_r13};
    assign oCursorAddr  = {r_r14, r_r15};
    assign oCursorStart = r_r10[4:0];
    assign oCursorEnd   = r_r11;
    assign oVideoEn     = r_mode[MODE_VIDEO];
    assign oHiRes       = r_mode[MODE_HIRES];
    assign oBlinkEn     = r_mode[MODE_BLINK];
    assign oAttrBlink   = r_mode[MODE_BLINK] & r_cnt[4];
    assign io.oIoData   = r_rdata;
    assign io.oIoAck    = r_ack;

    // Blank edge pulse and the undefined mode bits have no consumer.
    assign w_unused = w_bl_rise | r_mode[4] | r_mode[2] | r_mode[1];

endmodule

// File: tb/tb_mda_crtc.sv
// Self-checking bench for mda_crtc; read data is scoreboarded against oIoAck.
// Build with +define+MDA_CRTC_SHADOW_EN to exercise the shadowed start address.
module tb_mda_crtc;

    logic        clk;
    logic        rst;
    logic        vblank;
    logic        blank;
    logic [13:0] start_addr, cursor_addr;
    logic [4:0]  cursor_start, cursor_end;
    logic        cursor_on, attr_blink, video_en, hi_res, blink_en;

    mda_crtc_if bus ();

    mda_crtc dut (
        .iClk         (clk),
        .iRst         (rst),
        .io           (bus),
        .iVBlank      (vblank),
        .iBlank       (blank),
        .oStartAddr   (start_addr),
        .oCursorAddr  (cursor_addr),
        .oCursorStart (cursor_start),
        .oCursorEnd   (cursor_end),
        .oCursorOn    (cursor_on),
        .oAttrBlink   (attr_blink),
        .oVideoEn     (video_en),
        .oHiRes       (hi_res),
        .oBlinkEn     (blink_en)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt    = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every decoded access queues {is_read, data}; each ack pops one
    always @(negedge clk) begin
        if (!rst && bus.oIoAck) begin
            if (exp_q.size() == 0) begin
                check_eq("ack_spurious", {31'd0, bus.oIoAck}, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (e[8])
                    check_eq("rd_data", {24'd0, bus.oIoData}, {24'd0, e[7:0]});
            end
        end
    end

    // drivers
    task automatic io_cycle(input logic [15:0] a, input logic [7:0] d,
                            input bit wr, input bit rd, input logic [7:0] exp_rd);
        logic [15:0] off;
        off = a - 16'h03B0;
        @(negedge clk);
        bus.iIoAddr = a;
        bus.iIoData = d;
        bus.iIoWr   = wr;
        bus.iIoRd   = rd;
        if (off < 16'd16) begin
            if (wr)      exp_q.push_back({1'b0, 8'h00});
            else if (rd) exp_q.push_back({1'b1, exp_rd});
        end
        @(negedge clk);
        bus.iIoWr = 1'b0;
        bus.iIoRd = 1'b0;
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
        io_cycle(a, d, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic io_rd(input logic [15:0] a, input logic [7:0] exp_rd);
        io_cycle(a, 8'h00, 1'b0, 1'b1, exp_rd);
    endtask

    task automatic crtc_wr(input logic [4:0] idx, input logic [7:0] d);
        io_wr(16'h03B4, {3'b000, idx});
        io_wr(16'h03B5, d);
    endtask

    task automatic vb_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1;
            repeat (4) @(negedge clk);
            vblank = 1'b0;
            repeat (4) @(negedge clk);
            m_cnt = (m_cnt + 1) % 32;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        vblank = 1'b0;
        blank = 1'b1;
        bus.iIoAddr = 16'h0000;
        bus.iIoData = 8'h00;
        bus.iIoWr = 1'b0;
        bus.iIoRd = 1'b0;
        wait_cycles(3);
        check_eq("rst_ack",      {31'd0, bus.oIoAck}, 32'd0);
        check_eq("rst_iodata",   {24'd0, bus.oIoData}, 32'd0);
        check_eq("rst_video",    {31'd0, video_en}, 32'd0);
        check_eq("rst_cursor_on", {31'd0, cursor_on}, 32'd1);
        check_eq("rst_start",    {18'd0, start_addr}, 32'd0);
        check_eq("rst_attr",     {31'd0, attr_blink}, 32'd0);
        rst = 1'b0;
        wait_cycles(4);

        // status with blank high, vblank low
        io_rd(16'h03BA, 8'hF1);

        // cursor address through index/data pair, plus readback
        crtc_wr(5'h0E, 8'h07);
        crtc_wr(5'h0F, 8'hD0);
        check_eq("cursor_addr", {18'd0, cursor_addr}, 32'h07D0);
        io_rd(16'h03B5, 8'hD0);
        io_wr(16'h03B4, 8'h0E);
        io_rd(16'h03B5, 8'h07);
        io_rd(16'h03B4, 8'h0E);
        // index write uses only 5 bits
        io_wr(16'h03B0, 8'hEF);
        io_rd(16'h03B2, 8'h0F);
        // write and read together: write wins, only one ack
        io_cycle(16'h03B4, 8'h0E, 1'b1, 1'b1, 8'h00);
        io_rd(16'h03B1, 8'h07);

        // cursor modes
        crtc_wr(5'd10, 8'h20);
        check_eq("cursor_off", {31'd0, cursor_on}, 32'd0);
        crtc_wr(5'd10, 8'h4B);
        check_eq("cursor_start", {27'd0, cursor_start}, 32'h0B);
        vb_pulse(7);
        check_eq("fast_7", {31'd0, cursor_on}, {31'd0, m_cnt[3]});
        vb_pulse(1);
        check_eq("fast_8", {31'd0, cursor_on}, 32'd1);
        crtc_wr(5'd11, 8'h05);
        check_eq("cursor_end", {27'd0, cursor_end}, 32'h05);
        check_eq("start_gt_end", {27'd0, cursor_start}, 32'h0B);

        // mode register
        io_wr(16'h03B8, 8'h29);
        check_eq("hires", {31'd0, hi_res}, 32'd1);
        check_eq("video", {31'd0, video_en}, 32'd1);
        check_eq("blink_en", {31'd0, blink_en}, 32'd1);
        check_eq("attr_8", {31'd0, attr_blink}, 32'd0);
        vb_pulse(8);
        check_eq("attr_16", {31'd0, attr_blink}, 32'd1);
        io_rd(16'h03B8, 8'hFF);

        // start address, dropped writes, unreadable regs, out-of-range
        crtc_wr(5'd12, 8'h3F);
        crtc_wr(5'd13, 8'hFF);
        crtc_wr(5'd5, 8'h55);
        io_wr(16'h03C0, 8'h12);
        io_rd(16'h03C0, 8'h00);
        io_rd(16'h03AF, 8'h00);
`ifdef MDA_CRTC_SHADOW_EN
        check_eq("start_shadow", {18'd0, start_addr}, 32'h0000);
`else
        check_eq("start_live", {18'd0, start_addr}, 32'h3FFF);
`endif
        io_rd(16'h03B5, 8'h00);
        io_wr(16'h03B4, 8'h0C);
        io_rd(16'h03B5, 8'h00);
        io_rd(16'h03BB, 8'hFF);
        io_wr(16'h03BA, 8'h00);

        // vblank held high: counter reaches 17, shadow (if any) loads
        vblank = 1'b1;
        wait_cycles(4);
        m_cnt = m_cnt + 1;
        check_eq("start_after_vb", {18'd0, start_addr}, 32'h3FFF);
        io_rd(16'h03BA, 8'hF9);
        check_eq("pre_rst_cursor", {31'd0, cursor_on}, {31'd0, m_cnt[3]});
        check_eq("pre_rst_attr", {31'd0, attr_blink}, {31'd0, m_cnt[4]});

        // reset mid-frame
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_cursor_on", {31'd0, cursor_on}, 32'd1);
        check_eq("mrst_attr", {31'd0, attr_blink}, 32'd0);
        check_eq("mrst_video", {31'd0, video_en}, 32'd0);
        check_eq("mrst_hires", {31'd0, hi_res}, 32'd0);
        check_eq("mrst_start", {18'd0, start_addr}, 32'd0);
        check_eq("mrst_cursor", {18'd0, cursor_addr}, 32'd0);
        check_eq("mrst_iodata", {24'd0, bus.oIoData}, 32'd0);
        check_eq("mrst_ack", {31'd0, bus.oIoAck}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 1;
        wait_cycles(4);

        // counter restarted: vblank high after reset is one edge
        io_wr(16'h03B8, 8'h29);
        crtc_wr(5'd10, 8'h40);
        vblank = 1'b0;
        wait_cycles(4);
        vb_pulse(7);
        check_eq("post_rst_fast", {31'd0, cursor_on}, {31'd0, m_cnt[3]});
        check_eq("post_rst_attr", {31'd0, attr_blink}, {31'd0, m_cnt[4]});
        crtc_wr(5'd10, 8'h60);
        check_eq("slow_8", {31'd0, cursor_on}, 32'd0);
        vb_pulse(8);
        check_eq("slow_16", {31'd0, cursor_on}, 32'd1);
        check_eq("attr_16b", {31'd0, attr_blink}, 32'd1);
        vb_pulse(16);
        check_eq("wrap_slow", {31'd0, cursor_on}, {31'd0, m_cnt[4]});
        check_eq("wrap_attr", {31'd0, attr_blink}, 32'd0);
        io_wr(16'h03B8, 8'h08);
        check_eq("blink_dis", {31'd0, blink_en}, 32'd0);

        wait_cycles(4);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mda_crtc.md
Name: mda_crtc

Overview:
- CPU-side I/O controller for the MDA text display: a 6845-style index/data register file at 03B0h-03B7h, a mode control register at 03B8h, and a status register at 03BAh.
- Drives display configuration to the character generator: start address, cursor address and shape, video enable, and cursor/attribute blink phases.
- Lives in the cpu clock domain. Blanking inputs arrive asynchronously from the 25.175 MHz video domain.

Parameters:
- BASE, 16'h03B0, I/O base; decode covers BASE..BASE+15
- BLINK_BITS, 5, width of the vsync frame counter used for blink phases

Ports:
- iClk  in  1  cpu domain clock
- iRst  in  1  synchronous, active-high reset
- iIoAddr  in  16  I/O port address
- iIoData  in  8  I/O write data
- iIoWr  in  1  I/O write strobe, one cycle
- iIoRd  in  1  I/O read strobe, one cycle
- oIoData  out  8  read data, registered
- oIoAck  out  1  high one cycle after a decoded read or write
- iVBlank  in  1  vertical retrace, async level from video domain
- iBlank  in  1  display-not-enabled (h or v blank), async level
- oStartAddr  out  14  display start address {R12[5:0],R13}
- oCursorAddr  out  14  cursor address {R14[5:0],R15}
- oCursorStart  out  5  cursor top scanline, R10[4:0]
- oCursorEnd  out  5  cursor bottom scanline, R11[4:0]
- oCursorOn  out  1  cursor visible this frame
- oAttrBlink  out  1  blink-attribute phase
- oVideoEn  out  1  mode reg bit3
- oHiRes  out  1  mode reg bit0
- oBlinkEn  out  1  mode reg bit5

Behaviour:
- Reset:
  - All registers 0, index 0, frame counter 0.
  - oIoData=8'h00, oIoAck=0, oVideoEn=0, oCursorOn=1 (R10 mode 00 = steady).
- Decode, with off = iIoAddr-BASE valid when off<16:
  - off 0-7 even: index register, 5 bits. A write stores iIoData[4:0]. A read returns {3'b0,index}.
  - off 0-7 odd: data port to register[index].
    - Writable: R10 (7 bits), R11 (5), R12 (6), R13 (8), R14 (6), R15 (8).
    - Writes to R0-R9 and R16-R31 are dropped.
    - Readable: R14 and R15 only. Every other index reads 8'h00.
  - off 8: mode control, write only, 6 bits stored. A read returns 8'hFF.
  - off 10: status, read only: {4'hF, vblank_s, 2'b00, blank_s}. A write is ignored.
  - Any other offset: a write is ignored and a read returns 8'hFF.
- oIoAck:
  - Fires one cycle after any strobe with off<16; oIoData is valid in the same cycle.
  - oIoData holds its value until the next read.
  - iIoWr and iIoRd together in one cycle: the write wins and the read is dropped (no oIoAck for the read).
- Configuration outputs are combinational from the registers. An update is visible the cycle after the write.
- Synchronizers: iVBlank and iBlank each pass through 2 flops, giving vblank_s and blank_s. Status therefore lags the pins by 2-3 cycles.
- Frame counter:
  - Rising edge of vblank_s (3rd flop for edge detect) increments it.
  - Counter is BLINK_BITS wide and wraps 31->0.
- Cursor mode R10[6:5]:
  - 00: oCursorOn=1
  - 01: oCursorOn=0
  - 10: oCursorOn=cnt[3] (toggles every 8 frames)
  - 11: oCursorOn=cnt[4] (toggles every 16 frames)
- Attribute blink: oAttrBlink = oBlinkEn & cnt[4]. With oBlinkEn=0 it is 0.
- Cursor start > end is not an error. The values pass through unmodified.
- iRst asserted mid-frame clears the counter. Edge detection restarts with the 3rd flop reset to 0, so a vblank already high after reset counts as one edge.

Optional Feature:
- Macro MDA_CRTC_SHADOW_EN.
- Defined:
  - R12/R13 writes go to shadow registers.
  - oStartAddr loads from the shadow only on the vblank_s rising edge, giving tear-free scrolling.
  - Reading R12/R13 still returns 0.
  - Reset clears both the shadow and the live copy.
- Undefined: oStartAddr follows R12/R13 the cycle after the write.

Decomposition:
- Package mda_pkg holds:
  - register index constants (R_CUR_START=10 .. R_CUR_LO=15)
  - port offsets (OFF_MODE=8, OFF_STATUS=10)
  - mode bit positions
  - cursor-mode enum (CUR_STEADY, CUR_OFF, CUR_FAST, CUR_SLOW)
- One sub-module: mda_sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated twice.

Test Plan:
- Reset, then read 03BAh with iBlank=1, iVBlank=0 -> oIoData=8'hF1, oIoAck high one cycle later.
- Write 03B4h=0Eh, 03B5h=07h, 03B4h=0Fh, 03B5h=D0h -> oCursorAddr=14'h07D0; read back 03B5h -> D0h; select index 0Eh, read -> 07h.
- Write R10=20h (mode 01) -> oCursorOn=0. Write R10=4Bh, then pulse iVBlank 8 times -> oCursorOn toggles 0->1 at the 8th edge; oCursorStart=0Bh.
- Write 03B8h=29h -> oHiRes=1, oVideoEn=1, oBlinkEn=1. After 16 vblank edges oAttrBlink=1. Read 03B8h -> FFh.
- Write R12=3Fh, R13=FFh; write index 05h data 55h; access 03C0h -> oStartAddr=3FFFh; read R5 -> 00h; no ack for 03C0h. With MDA_CRTC_SHADOW_EN, oStartAddr stays 0000h until the next vblank edge.
- Assert iRst mid-frame with the counter at 17 -> counter 0, all outputs at reset values on the following cycle.
